mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NumHosts, default 3, number of requesting hosts (2..8).
REQ-002 SHALL have parameter AddrWidth, default 32, address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width; byte enable width is DataWidth/8.
REQ-004 SHALL have parameter MaxOutstanding, default 2, maximum number of granted transactions awaiting a response (1..8).
REQ-005 SHALL use one clock, clk_i; reset is rst_i, synchronous and active-high.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 host_req_i  in  [NumHosts]  per-host request.
REQ-009 host_addr_i / host_we_i / host_be_i / host_wdata_i  in  [NumHosts][AddrWidth] / [NumHosts] / [NumHosts][DataWidth/8] / [NumHosts][DataWidth]  per-host command fields.
REQ-010 host_gnt_o  out  [NumHosts]  per-host grant, one-hot or zero.
REQ-011 host_rvalid_o / host_err_o  out  [NumHosts]  per-host response valid and error.
REQ-012 host_rdata_o  out  [NumHosts][DataWidth]  per-host read data.
REQ-013 dev_req_o / dev_we_o / dev_be_o / dev_addr_o / dev_wdata_o  out  1 / 1 / DataWidth/8 / AddrWidth / DataWidth  device command.
REQ-014 dev_rvalid_i / dev_err_i / dev_rdata_i  in  1 / 1 / DataWidth  device response; in order, latency >= 1 cycle.
REQ-015 outstanding_o  out  $clog2(MaxOutstanding+1)  count of granted, unanswered transactions.
REQ-016 spurious_rsp_o  out  1  sticky flag: response received with nothing outstanding.

Function
REQ-017 Grant is combinational, in the same cycle as the request; at most one host_gnt_o bit set per cycle.
REQ-018 No grant SHALL be issued while outstanding_o == MaxOutstanding (registered count), even if a response pops in that cycle.
REQ-019 dev_req_o SHALL equal |host_gnt_o; dev command fields SHALL be muxed from the granted host, and SHALL be 0 when no grant is issued.
REQ-020 Each grant SHALL push the granted host index into an in-order ID FIFO; each dev_rvalid_i SHALL pop the head.
REQ-021 On dev_rvalid_i with a non-empty FIFO, host_rvalid_o[head], host_err_o[head] and host_rdata_o[head] SHALL follow dev_rvalid_i, dev_err_i and dev_rdata_i in the same cycle; all other hosts' response outputs SHALL be 0.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged; a pop-only SHALL decrement it; a push-only SHALL increment it.
REQ-023 On dev_rvalid_i with count 0, the response SHALL be dropped, no host_rvalid_o SHALL assert, and spurious_rsp_o SHALL be set until reset.
REQ-024 A host SHALL hold its request and command fields stable until it is granted; the arbiter does not latch ungranted requests.

Reset
REQ-025 While rst_i is high at a clk_i edge: FIFO empties, outstanding_o becomes 0, spurious_rsp_o becomes 0, and the priority pointer becomes 0.
REQ-026 While rst_i is high, host_gnt_o, dev_req_o, host_rvalid_o and host_err_o SHALL be 0, and dev_rvalid_i SHALL be ignored.
REQ-027 Responses to transactions issued before a mid-operation reset that arrive after reset release with count 0 SHALL set spurious_rsp_o (REQ-023).

Configuration
REQ-028 With MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
- Search starts at the priority pointer.
- After a grant to host k, the pointer becomes (k+1) mod NumHosts, wrapping from NumHosts-1 to 0.
- The pointer is unchanged in cycles without a grant.
REQ-029 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority, lowest index wins; no pointer register exists.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the host-index width function/constant and the response-routing struct (valid, err, data).
REQ-031 The ID FIFO SHALL be the sub-module mem_arb_id_fifo.
- Parameters: Depth=MaxOutstanding, Width=host index width.
- Ports: push/pop/head/count/full/empty.
- Same clk_i/rst_i.

Verification
REQ-032 Fixed priority, NumHosts=3: hosts 0,1,2 all request continuously with 1-cycle device latency -> host 1 and host 2 are never granted while host 0 requests.
REQ-033 Round-robin: all 3 hosts request continuously -> grants in the order 0,1,2,0,1,2; host_rvalid_o follows the same order one cycle later.
REQ-034 MaxOutstanding=2, device latency 3 cycles, host 1 requesting continuously -> two grants, then gnt low until the first response; outstanding_o never exceeds 2.
REQ-035 Response with dev_err_i=1, dev_rdata_i=0xDEADBEEF for host 2 -> host_err_o[2]=1 and host_rdata_o[2]=0xDEADBEEF in the same cycle; hosts 0 and 1 see 0.
REQ-036 dev_rvalid_i pulsed with count 0 -> no host_rvalid_o, and spurious_rsp_o=1 until rst_i.
REQ-037 rst_i asserted with 2 outstanding, then responses arrive -> outstanding_o=0, spurious_rsp_o=1, and the next grant goes to host 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter and its ID FIFO.
package mem_arb_pkg;

    // Widest data bus the response-routing struct can carry.
    localparam int MaxDataWidth = 64;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic                    err;
        logic [MaxDataWidth-1:0] data;
    } rsp_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of granted host indices; the head names the host owed the next response.
module mem_arb_id_fifo #(
    parameter int Depth = 2,
    parameter int Width = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [Width-1:0]           push_data,
    input  logic                       pop,
    output logic [Width-1:0]           head,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth+1);

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(Depth-1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (cnt == CW'(Depth));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-host to single memory port arbiter with in-order response routing.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (host 0 highest).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NumHosts       = 3,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NumHosts-1:0]                        host_req_i,
    input  logic [NumHosts-1:0][AddrWidth-1:0]         host_addr_i,
    input  logic [NumHosts-1:0]                        host_we_i,
    input  logic [NumHosts-1:0][DataWidth/8-1:0]       host_be_i,
    input  logic [NumHosts-1:0][DataWidth-1:0]         host_wdata_i,
    output logic [NumHosts-1:0]                        host_gnt_o,
    output logic [NumHosts-1:0]                        host_rvalid_o,
    output logic [NumHosts-1:0]                        host_err_o,
    output logic [NumHosts-1:0][DataWidth-1:0]         host_rdata_o,
    output logic                                       dev_req_o,
    output logic                                       dev_we_o,
    output logic [DataWidth/8-1:0]                     dev_be_o,
    output logic [AddrWidth-1:0]                       dev_addr_o,
    output logic [DataWidth-1:0]                       dev_wdata_o,
    input  logic                                       dev_rvalid_i,
    input  logic                                       dev_err_i,
    input  logic [DataWidth-1:0]                       dev_rdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]        outstanding_o,
    output logic                                       spurious_rsp_o
);

    localparam int HW = idx_width(NumHosts);

    logic          grant;
    logic [HW-1:0] gnt_idx;
    logic          fifo_full, fifo_empty;
    logic [HW-1:0] fifo_head;
    logic          pop;
    rsp_t          rsp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [HW-1:0]           ptr;
    logic [2*NumHosts-1:0]   req_dbl;
    logic [NumHosts-1:0]     req_rot;
    logic [HW:0]             off, sum;

    // Rotate requests so the pointer host sits at bit 0, then pick the lowest set bit.
    always_comb begin
        req_dbl = {host_req_i, host_req_i} >> ptr;
        req_rot = req_dbl[NumHosts-1:0];
        off     = '0;
        for (int i = NumHosts-1; i >= 0; i--) begin
            if (req_rot[i]) off = (HW+1)'(i);
        end
        sum     = {1'b0, ptr} + off;
        gnt_idx = (sum >= (HW+1)'(NumHosts)) ? HW'(sum - (HW+1)'(NumHosts)) : sum[HW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (gnt_idx == HW'(NumHosts-1)) ? '0 : gnt_idx + HW'(1);
        end
    end
`else
    always_comb begin
        gnt_idx = '0;
        for (int i = NumHosts-1; i >= 0; i--) begin
            if (host_req_i[i]) gnt_idx = HW'(i);
        end
    end
`endif

    // Full is derived from the registered count, so a same-cycle response never frees a slot.
    assign grant = (|host_req_i) && !fifo_full && !rst_i;

    always_comb begin
        host_gnt_o  = '0;
        dev_req_o   = 1'b0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_addr_o  = '0;
        dev_wdata_o = '0;
        if (grant) begin
            host_gnt_o  = NumHosts'(1) << gnt_idx;
            dev_req_o   = 1'b1;
            dev_we_o    = host_we_i[gnt_idx];
            dev_be_o    = host_be_i[gnt_idx];
            dev_addr_o  = host_addr_i[gnt_idx];
            dev_wdata_o = host_wdata_i[gnt_idx];
        end
    end

    mem_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (HW)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (grant),
        .push_data (gnt_idx),
        .pop       (pop),
        .head      (fifo_head),
        .count     (outstanding_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pop = dev_rvalid_i && !fifo_empty && !rst_i;

    always_comb begin
        rsp.valid = pop;
        rsp.err   = pop && dev_err_i;
        rsp.data  = pop ? MaxDataWidth'(dev_rdata_i) : '0;
    end

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int h = 0; h < NumHosts; h++) begin
            if (rsp.valid && (fifo_head == HW'(h))) begin
                host_rvalid_o[h] = 1'b1;
                host_err_o[h]    = rsp.err;
                host_rdata_o[h]  = rsp.data[DataWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spurious_rsp_o <= 1'b0;
        end else if (dev_rvalid_i && fifo_empty) begin
            spurious_rsp_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter at default parameters.
module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N-1:0]           host_req_i;
    logic [N-1:0][AW-1:0]   host_addr_i;
    logic [N-1:0]           host_we_i;
    logic [N-1:0][DW/8-1:0] host_be_i;
    logic [N-1:0][DW-1:0]   host_wdata_i;
    logic [N-1:0]           host_gnt_o;
    logic [N-1:0]           host_rvalid_o;
    logic [N-1:0]           host_err_o;
    logic [N-1:0][DW-1:0]   host_rdata_o;
    logic                   dev_req_o;
    logic                   dev_we_o;
    logic [DW/8-1:0]        dev_be_o;
    logic [AW-1:0]          dev_addr_o;
    logic [DW-1:0]          dev_wdata_o;
    logic                   dev_rvalid_i;
    logic                   dev_err_i;
    logic [DW-1:0]          dev_rdata_i;
    logic [$clog2(MO+1)-1:0] outstanding_o;
    logic                   spurious_rsp_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .NumHosts(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .host_req_i     (host_req_i),
        .host_addr_i    (host_addr_i),
        .host_we_i      (host_we_i),
        .host_be_i      (host_be_i),
        .host_wdata_i   (host_wdata_i),
        .host_gnt_o     (host_gnt_o),
        .host_rvalid_o  (host_rvalid_o),
        .host_err_o     (host_err_o),
        .host_rdata_o   (host_rdata_o),
        .dev_req_o      (dev_req_o),
        .dev_we_o       (dev_we_o),
        .dev_be_o       (dev_be_o),
        .dev_addr_o     (dev_addr_o),
        .dev_wdata_o    (dev_wdata_o),
        .dev_rvalid_i   (dev_rvalid_i),
        .dev_err_i      (dev_err_i),
        .dev_rdata_i    (dev_rdata_i),
        .outstanding_o  (outstanding_o),
        .spurious_rsp_o (spurious_rsp_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        host_req_i   = '0;
        dev_rvalid_i = 1'b0;
        dev_err_i    = 1'b0;
        dev_rdata_i  = '0;
    endtask

    initial begin
        logic [N-1:0] exp_g, prev_g;
        int           idx, prev_idx;

        for (int h = 0; h < N; h++) begin
            host_addr_i[h]  = 32'h1000 * (h + 1);
            host_we_i[h]    = h[0];
            host_be_i[h]    = 4'hF;
            host_wdata_i[h] = 32'hC0DE_0000 + h;
        end
        idle();
        rst_i = 1'b1;
        tick();
        tick();

        // activity during reset is ignored
        host_req_i   = '1;
        dev_rvalid_i = 1'b1;
        #1;
        chk("rst_gnt",    64'(host_gnt_o),    64'(0));
        chk("rst_devreq", 64'(dev_req_o),     64'(0));
        chk("rst_rvalid", 64'(host_rvalid_o), 64'(0));
        chk("rst_err",    64'(host_err_o),    64'(0));
        tick();
        chk("rst_outst",  64'(outstanding_o), 64'(0));
        chk("rst_spur",   64'(spurious_rsp_o), 64'(0));
        rst_i = 1'b0;
        idle();
        tick();

        // all hosts request, device answers one cycle later
        prev_g = '0;
        prev_idx = 0;
        host_req_i = 3'b111;
        for (int k = 0; k < 6; k++) begin
            dev_rvalid_i = (k > 0);
            dev_rdata_i  = 32'hA000 + k;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            idx = k % 3;
`else
            idx = 0;
`endif
            exp_g = 3'b001 << idx;
            #1;
            chk("arb_gnt",    64'(host_gnt_o),    64'(exp_g));
            chk("arb_addr",   64'(dev_addr_o),    64'(32'h1000 * (idx + 1)));
            chk("arb_rvalid", 64'(host_rvalid_o), 64'(prev_g));
            chk("arb_outst",  64'(outstanding_o), 64'((k == 0) ? 0 : 1));
            if (k > 0) chk("arb_rdata", 64'(host_rdata_o[prev_idx]), 64'(32'hA000 + k));
            prev_g   = exp_g;
            prev_idx = idx;
            tick();
        end
        host_req_i   = '0;
        dev_rvalid_i = 1'b1;
        #1;
        chk("drain_rvalid", 64'(host_rvalid_o), 64'(prev_g));
        tick();
        idle();
        chk("drain_outst", 64'(outstanding_o), 64'(0));
        chk("drain_spur",  64'(spurious_rsp_o), 64'(0));

        // host 1 alone, 3-cycle device latency: window fills at 2
        host_req_i = 3'b010;
        for (int c = 0; c < 5; c++) begin
            dev_rvalid_i = (c >= 3);
            #1;
            chk("lat_gnt",    64'(host_gnt_o),    64'((c < 2 || c == 4) ? 3'b010 : 3'b000));
            chk("lat_outst",  64'(outstanding_o), 64'((c == 0) ? 0 : (c == 4) ? 1 : (c == 1) ? 1 : 2));
            chk("lat_rvalid", 64'(host_rvalid_o), 64'((c >= 3) ? 3'b010 : 3'b000));
            tick();
        end
        host_req_i   = '0;
        dev_rvalid_i = 1'b1;
        tick();
        idle();
        chk("lat_empty", 64'(outstanding_o), 64'(0));

        // error response routed to host 2 only
        host_req_i = 3'b100;
        #1;
        chk("err_gnt", 64'(host_gnt_o), 64'(3'b100));
        tick();
        host_req_i   = '0;
        dev_rvalid_i = 1'b1;
        dev_err_i    = 1'b1;
        dev_rdata_i  = 32'hDEADBEEF;
        #1;
        chk("err_rvalid", 64'(host_rvalid_o),   64'(3'b100));
        chk("err_err",    64'(host_err_o),      64'(3'b100));
        chk("err_rdata2", 64'(host_rdata_o[2]), 64'(32'hDEADBEEF));
        chk("err_rdata0", 64'(host_rdata_o[0]), 64'(0));
        chk("err_rdata1", 64'(host_rdata_o[1]), 64'(0));
        tick();
        idle();

        // response with nothing outstanding
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h5555;
        #1;
        chk("spur_rvalid", 64'(host_rvalid_o), 64'(0));
        tick();
        idle();
        chk("spur_set", 64'(spurious_rsp_o), 64'(1));
        tick();
        tick();
        chk("spur_sticky", 64'(spurious_rsp_o), 64'(1));

        // mid-operation reset with two outstanding, late responses afterwards
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst2_spur", 64'(spurious_rsp_o), 64'(0));
        host_req_i = 3'b110;
        tick();
        tick();
        #1;
        chk("pre_outst", 64'(outstanding_o), 64'(2));
        chk("pre_full",  64'(host_gnt_o),    64'(0));
        rst_i = 1'b1;
        #1;
        chk("rst2_gnt", 64'(host_gnt_o), 64'(0));
        tick();
        rst_i = 1'b0;
        host_req_i = '0;
        chk("post_outst", 64'(outstanding_o), 64'(0));
        dev_rvalid_i = 1'b1;
        #1;
        chk("late_rvalid0", 64'(host_rvalid_o), 64'(0));
        tick();
        chk("late_rvalid1", 64'(host_rvalid_o), 64'(0));
        chk("late_spur",    64'(spurious_rsp_o), 64'(1));
        tick();
        dev_rvalid_i = 1'b0;
        chk("late_outst", 64'(outstanding_o), 64'(0));
        host_req_i = 3'b111;
        #1;
        chk("post_gnt", 64'(host_gnt_o), 64'(3'b001));
        tick();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
